// File: rtl/npu_inst_sequencer_pkg.sv
// Shared types and constants for the NPU instruction-ring sequencer.
package npu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_FETCH,
        S_DISPATCH,
        S_EXEC,
        S_WRITEBACK,
        S_HALTED
    } seq_state_e;

    localparam logic [7:0] HALT_OP_DEF = 8'hFF;

    // Done word: MSB is the complete flag, the low FLAG_W-1 bits carry engine status.
    localparam logic DONE_COMPLETE = 1'b1;

endpackage

// File: rtl/npu_inst_sequencer_if.sv
// Memory-side and engine-side bus of the sequencer; master = sequencer.
interface npu_inst_sequencer_if #(
    parameter int INST_W  = 128,
    parameter int SLOT_AW = 8,
    parameter int FLAG_W  = 8
);
    logic [SLOT_AW-1:0]  valid_address;
    logic                valid_clken;
    logic                valid_chipselect;
    logic                valid_write;
    logic [FLAG_W-1:0]   valid_writedata;
    logic [FLAG_W-1:0]   valid_readdata;

    logic [SLOT_AW-1:0]  inst_address;
    logic                inst_clken;
    logic                inst_chipselect;
    logic                inst_write;
    logic [INST_W/8-1:0] inst_byteenable;
    logic [INST_W-1:0]   inst_readdata;

    logic [SLOT_AW-1:0]  done_address;
    logic                done_clken;
    logic                done_chipselect;
    logic                done_write;
    logic [FLAG_W-1:0]   done_writedata;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [INST_W-1:0]   cmd_data;
    logic [SLOT_AW-1:0]  cmd_slot;
    logic                exec_done;
    logic [FLAG_W-2:0]   exec_status;

    modport master (
        output valid_address, valid_clken, valid_chipselect, valid_write, valid_writedata,
        input  valid_readdata,
        output inst_address, inst_clken, inst_chipselect, inst_write, inst_byteenable,
        input  inst_readdata,
        output done_address, done_clken, done_chipselect, done_write, done_writedata,
        output cmd_valid, cmd_data, cmd_slot,
        input  cmd_ready, exec_done, exec_status
    );

    modport slave (
        input  valid_address, valid_clken, valid_chipselect, valid_write, valid_writedata,
        output valid_readdata,
        input  inst_address, inst_clken, inst_chipselect, inst_write, inst_byteenable,
        output inst_readdata,
        input  done_address, done_clken, done_chipselect, done_write, done_writedata,
        input  cmd_valid, cmd_data, cmd_slot,
        output cmd_ready, exec_done, exec_status
    );
endinterface

// File: rtl/npu_inst_sequencer_mem_rd_wait.sv
// Tracks an outstanding on-chip memory read; rdata_valid rises RD_LAT cycles after start.
module npu_mem_rd_wait #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic rdata_valid
);
    logic [RD_LAT:1] vld_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= start;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign rdata_valid = vld_pipe[RD_LAT];
endmodule

// File: rtl/npu_inst_sequencer.sv
// Instruction-ring sequencer: polls valid flags in ring order, fetches, dispatches, retires.
module npu_inst_sequencer
    import npu_seq_pkg::*;
#(
    parameter int         INST_W  = 128,
    parameter int         SLOT_AW = 8,
    parameter int         FLAG_W  = 8,
    parameter int         RD_LAT  = 1,
    parameter logic [7:0] HALT_OP = HALT_OP_DEF,
    parameter int         CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    npu_inst_sequencer_if.master bus,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_W-1:0]     retired_count
);
    seq_state_e          state_q;
    logic [SLOT_AW-1:0]  ptr_q;
    logic                vcs_q, vwr_q, ics_q, dwr_q;
    logic [FLAG_W-1:0]   dwdata_q;
    logic                cmd_valid_q;
    logic [INST_W-1:0]   cmd_data_q;
    logic                halt_q, halted_q;
    logic [CNT_W-1:0]    retired_q;
    logic                rd_start, rd_valid;

    // Valid-flag reads and instruction reads never overlap, so one tracker serves both.
    assign rd_start = (vcs_q & ~vwr_q) | ics_q;

    npu_mem_rd_wait #(.RD_LAT(RD_LAT)) u_rd_wait (
        .clk         (clk),
        .reset       (reset),
        .start       (rd_start),
        .rdata_valid (rd_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            vcs_q       <= 1'b0;
            vwr_q       <= 1'b0;
            ics_q       <= 1'b0;
            dwr_q       <= 1'b0;
            dwdata_q    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            halt_q      <= 1'b0;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            vcs_q <= 1'b0;
            vwr_q <= 1'b0;
            ics_q <= 1'b0;
            dwr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_POLL;
                        vcs_q   <= 1'b1;
                    end
                end
                S_POLL: begin
                    if (rd_valid) begin
                        if (!enable) begin
                            state_q <= S_IDLE;
                        end else if (bus.valid_readdata != '0) begin
                            state_q <= S_FETCH;
                            ics_q   <= 1'b1;
                        end else begin
                            vcs_q <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (rd_valid) begin
                        cmd_data_q <= bus.inst_readdata;
                        if (bus.inst_readdata[INST_W-1 -: 8] == HALT_OP) begin
                            halt_q   <= 1'b1;
                            dwdata_q <= {DONE_COMPLETE, {(FLAG_W-1){1'b0}}};
                            vcs_q    <= 1'b1;
                            vwr_q    <= 1'b1;
                            dwr_q    <= 1'b1;
                            state_q  <= S_WRITEBACK;
                        end else begin
                            halt_q      <= 1'b0;
                            cmd_valid_q <= 1'b1;
                            state_q     <= S_DISPATCH;
                        end
                    end
                end
                S_DISPATCH: begin
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (bus.exec_done) begin
                        dwdata_q <= {DONE_COMPLETE, bus.exec_status};
                        vcs_q    <= 1'b1;
                        vwr_q    <= 1'b1;
                        dwr_q    <= 1'b1;
                        state_q  <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    retired_q <= retired_q + CNT_W'(1);
                    ptr_q     <= ptr_q + SLOT_AW'(1);
                    if (halt_q) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALTED;
                    end else if (enable) begin
                        vcs_q   <= 1'b1;
                        state_q <= S_POLL;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALTED: begin
                    if (!enable) begin
                        halted_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.valid_address    = ptr_q;
    assign bus.valid_clken      = 1'b1;
    assign bus.valid_chipselect = vcs_q;
    assign bus.valid_write      = vwr_q;
    assign bus.valid_writedata  = '0;
    assign bus.inst_address     = ptr_q;
    assign bus.inst_clken       = 1'b1;
    assign bus.inst_chipselect  = ics_q;
    assign bus.inst_write       = 1'b0;
    assign bus.inst_byteenable  = '1;
    assign bus.done_address     = ptr_q;
    assign bus.done_clken       = 1'b1;
    assign bus.done_chipselect  = dwr_q;
    assign bus.done_write       = dwr_q;
    assign bus.done_writedata   = dwdata_q;
    assign bus.cmd_valid        = cmd_valid_q;
    assign bus.cmd_data         = cmd_data_q;
    assign bus.cmd_slot         = ptr_q;

    assign busy          = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted        = halted_q;
    assign retired_count = retired_q;
endmodule
